// File: rtl/ltc2333_pkg.sv
`default_nettype none
// ============================================================================
// Module : ltc2333_pkg
// Brief  : Shared types and the channel round-robin helper for the LTC2333
//          sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package ltc2333_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CNV_HI    = 3'd1,
    CONV_WAIT = 3'd2,
    SHIFT     = 3'd3,
    GAP       = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] chan;
    logic [2:0] span;
    logic       rsv;
  } ltc2333_ctrl_t;

  // First set bit of mask at or above cur, wrapping 7->0; cur if mask is empty.
  function automatic logic [2:0] next_chan(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ltc2333_sck_gen.sv
`default_nettype none
// ============================================================================
// Module : ltc2333_sck_gen
// Brief  : SCKI divider; idles low, emits SCK_CYCLES periods while run is high.
// Rev    : 1.0 - initial release
// ============================================================================
module ltc2333_sck_gen #(
  parameter int unsigned SCK_HALF   = 2,
  parameter int unsigned SCK_CYCLES = 12
) (
  input  logic clk,
  input  logic aresetn,
  input  logic run,
  output logic scki,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic done
);

  localparam int unsigned c_hw = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [c_hw-1:0] r_half;
  logic [7:0]      r_per;
  logic            r_scki;
  logic            w_tick;

  // Pulses flag the clk edge on which scki is about to change.
  assign w_tick     = run && (r_half == c_hw'(SCK_HALF - 1));
  assign rise_pulse = w_tick && !r_scki;
  assign fall_pulse = w_tick && r_scki;
  assign done       = fall_pulse && (r_per == 8'(SCK_CYCLES - 1));
  assign scki       = r_scki;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_half <= '0;
      r_per  <= '0;
      r_scki <= 1'b0;
    end else if (!run || done) begin
      r_half <= '0;
      r_per  <= '0;
      r_scki <= 1'b0;
    end else if (w_tick) begin
      r_half <= '0;
      r_scki <= ~r_scki;
      if (r_scki) r_per <= r_per + 8'd1;
    end else begin
      r_half <= r_half + c_hw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ltc2333_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ltc2333_sequencer
// Brief  : CNV / conversion-wait / SCKI+SDI packet sequencer for the LTC2333.
//          Define LTC2333_BUSY_WAIT_EN to end the conversion wait on BUSY.
// Rev    : 1.0 - initial release
// ============================================================================
module ltc2333_sequencer
  import ltc2333_pkg::*;
#(
  parameter int unsigned CNV_HIGH_CYC = 4,
  parameter int unsigned CONV_CYC     = 50,
  parameter int unsigned SCK_HALF     = 2,
  parameter int unsigned SCK_CYCLES   = 12,
  parameter int unsigned GAP_CYC      = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        free_run,
  input  logic [31:0] period,
  input  logic        start,
  input  logic [7:0]  chan_mask,
  input  logic [2:0]  softspan,
  input  logic        busy,
  output logic        cnv,
  output logic        scki,
  output logic        sdi,
  output logic        active,
  output logic [31:0] cnv_count,
  output logic        overrun
);

  localparam logic [15:0] c_cnv_last = 16'(CNV_HIGH_CYC - 1);
  localparam logic [15:0] c_conv_last = 16'(CONV_CYC - 1);
  localparam logic [15:0] c_gap_last = 16'(GAP_CYC - 1);

  seq_state_t    r_state;
  logic [15:0]   r_cnt;
  logic [31:0]   r_pcnt;
  logic          r_cnv;
  logic          r_sdi;
  logic [7:0]    r_sr;
  logic          r_active;
  logic [31:0]   r_cnv_count;
  logic          r_overrun;
  logic [2:0]    r_chan;
  logic [7:0]    r_mask;
  logic [2:0]    r_span;
  logic          w_fr_hit;
  logic          w_trig;
  logic          w_run;
  logic          w_sck_fall;
  logic          w_sck_done;
  logic          w_sck_rise_unused;
  logic          w_conv_done;
  logic          w_wdog;
  ltc2333_ctrl_t w_ctrl;
  logic [7:0]    w_word;

  assign w_fr_hit = (r_pcnt == period - 32'd1);
  assign w_trig   = enable && (chan_mask != 8'd0) && (free_run ? w_fr_hit : start);
  assign w_run    = (r_state == SHIFT);
  assign w_ctrl   = '{v: 1'b1, chan: r_chan, span: r_span, rsv: 1'b0};
  assign w_word   = w_ctrl;

`ifdef LTC2333_BUSY_WAIT_EN
  localparam logic [15:0] c_wdog_last = 16'(4 * CONV_CYC - 1);
  logic r_busy_s1;
  logic r_busy_s2;
  logic r_busy_seen;

  // The falling edge only counts once BUSY has been observed high.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_busy_s1   <= 1'b0;
      r_busy_s2   <= 1'b0;
      r_busy_seen <= 1'b0;
    end else begin
      r_busy_s1 <= busy;
      r_busy_s2 <= r_busy_s1;
      if (r_state != CONV_WAIT) r_busy_seen <= 1'b0;
      else if (r_busy_s2)       r_busy_seen <= 1'b1;
    end
  end

  assign w_conv_done = r_busy_seen && !r_busy_s2;
  assign w_wdog      = (r_cnt == c_wdog_last);
`else
  logic w_unused_busy;
  assign w_unused_busy = busy;
  assign w_conv_done   = (r_cnt == c_conv_last);
  assign w_wdog        = 1'b0;
`endif

  ltc2333_sck_gen #(
    .SCK_HALF   (SCK_HALF),
    .SCK_CYCLES (SCK_CYCLES)
  ) u_sck_gen (
    .clk        (clk),
    .aresetn    (aresetn),
    .run        (w_run),
    .scki       (scki),
    .rise_pulse (w_sck_rise_unused),
    .fall_pulse (w_sck_fall),
    .done       (w_sck_done)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_pcnt <= '0;
    end else if (!(enable && free_run) || w_fr_hit) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cnv       <= 1'b0;
      r_sdi       <= 1'b0;
      r_sr        <= '0;
      r_active    <= 1'b0;
      r_cnv_count <= '0;
      r_overrun   <= 1'b0;
      r_chan      <= '0;
      r_mask      <= '0;
      r_span      <= '0;
    end else begin
      if (!enable)                           r_overrun <= 1'b0;
      else if (w_trig && r_state != IDLE)    r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_state     <= CNV_HI;
            r_cnt       <= '0;
            r_cnv       <= 1'b1;
            r_active    <= 1'b1;
            r_cnv_count <= r_cnv_count + 32'd1;
            r_mask      <= chan_mask;
            r_span      <= softspan;
            r_chan      <= next_chan(chan_mask, r_chan);
          end
        end
        CNV_HI: begin
          if (r_cnt == c_cnv_last) begin
            r_state <= CONV_WAIT;
            r_cnt   <= '0;
            r_cnv   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        CONV_WAIT: begin
          if (w_conv_done || w_wdog) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_sdi   <= w_word[7];
            r_sr    <= {w_word[6:0], 1'b0};
            if (w_wdog) r_overrun <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        SHIFT: begin
          // SDI moves with the scki fall so it is stable across the ADC's rise.
          if (w_sck_done) begin
            r_state <= GAP;
            r_sdi   <= 1'b0;
          end else if (w_sck_fall) begin
            r_sdi <= r_sr[7];
            r_sr  <= {r_sr[6:0], 1'b0};
          end
        end
        GAP: begin
          if (r_cnt == c_gap_last) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_chan   <= next_chan(r_mask, r_chan + 3'd1);
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cnv       = r_cnv;
  assign sdi       = r_sdi;
  assign active    = r_active;
  assign cnv_count = r_cnv_count;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ltc2333_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ltc2333_sequencer
// Brief  : Directed/randomised bench for ltc2333_sequencer (default build).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ltc2333_sequencer;

  localparam int CNV_HIGH_CYC = 4;
  localparam int CONV_CYC     = 50;
  localparam int SCK_HALF     = 2;
  localparam int SCK_CYCLES   = 12;
  localparam int GAP_CYC      = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        free_run;
  logic [31:0] period;
  logic        start;
  logic [7:0]  chan_mask;
  logic [2:0]  softspan;
  logic        busy;
  logic        cnv;
  logic        scki;
  logic        sdi;
  logic        active;
  logic [31:0] cnv_count;
  logic        overrun;

  ltc2333_sequencer dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .enable    (enable),
    .free_run  (free_run),
    .period    (period),
    .start     (start),
    .chan_mask (chan_mask),
    .softspan  (softspan),
    .busy      (busy),
    .cnv       (cnv),
    .scki      (scki),
    .sdi       (sdi),
    .active    (active),
    .cnv_count (cnv_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnv_rise;
    int         cnv_len;
    int         first_rise;
    int         rises;
    logic [11:0] bits;
    int         last_fall;
    int         active_fall;
  } pkt_t;

  pkt_t pk_q[$];
  pkt_t cur;
  bit   open = 1'b0;
  int   cyc = 0;
  int   n_cnv_rises = 0;
  logic p_cnv = 1'b0, p_scki = 1'b0, p_active = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   m_ptr = 0;
  int   m_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Packet recorder: observes the pins once per cycle on the falling clk edge.
  always @(negedge clk) begin
    if (!aresetn) begin
      open = 1'b0;
      p_cnv = 1'b0; p_scki = 1'b0; p_active = 1'b0;
    end else begin
      if (cnv && !p_cnv) begin
        open = 1'b1;
        n_cnv_rises++;
        cur.cnv_rise = cyc; cur.cnv_len = 0; cur.first_rise = -1; cur.rises = 0;
        cur.bits = '0; cur.last_fall = -1; cur.active_fall = -1;
      end
      if (open && cnv) cur.cnv_len++;
      if (open && scki && !p_scki) begin
        if (cur.rises == 0) cur.first_rise = cyc;
        cur.rises++;
        cur.bits = {cur.bits[10:0], sdi};
      end
      if (open && !scki && p_scki) cur.last_fall = cyc;
      if (open && !active && p_active) begin
        cur.active_fall = cyc;
        pk_q.push_back(cur);
        open = 1'b0;
      end
      p_cnv = cnv; p_scki = scki; p_active = active;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_set(input logic [7:0] m, input int from);
    for (int k = 0; k < 8; k++) if (m[(from + k) % 8]) return (from + k) % 8;
    return from;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pops one recorded packet and checks it against the round-robin/timing model.
  task automatic check_pkt(input string tag, input logic [7:0] mask, input logic [2:0] span,
                           output int rise);
    pkt_t p;
    int c, w;
    logic [11:0] exp_bits;
    w = 0;
    rise = -1;
    while (pk_q.size() == 0 && w < 800) begin tick(); w++; end
    check({tag, "_arrive"}, 64'(pk_q.size() != 0), 64'd1);
    if (pk_q.size() != 0) begin
      p = pk_q.pop_front();
      c = first_set(mask, m_ptr);
      m_ptr = first_set(mask, (c + 1) % 8);
      m_count++;
      exp_bits = {1'b1, 3'(c), span, 1'b0, 4'b0000};
      rise = p.cnv_rise;
      check({tag, "_cnvlen"}, 64'(p.cnv_len), 64'(CNV_HIGH_CYC));
      check({tag, "_sck1"}, 64'(p.first_rise - p.cnv_rise), 64'(CNV_HIGH_CYC + CONV_CYC + SCK_HALF));
      check({tag, "_nrise"}, 64'(p.rises), 64'(SCK_CYCLES));
      check({tag, "_sdi"}, 64'(p.bits), 64'(exp_bits));
      check({tag, "_gap"}, 64'(p.active_fall - p.last_fall), 64'(GAP_CYC));
    end
  endtask

  task automatic wait_rises(input string tag, input int n);
    int w;
    w = 0;
    while (!(open && cur.rises >= n) && w < 600) begin tick(); w++; end
    check({tag, "_reach"}, 64'(open && cur.rises >= n), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, prev, base;
    logic [7:0] m;
    logic [2:0] s;
    aresetn = 1'b0; enable = 1'b0; free_run = 1'b0; period = '0; start = 1'b0;
    chan_mask = '0; softspan = '0; busy = 1'b0;
    repeat (3) tick();
    check("rst_cnv", 64'(cnv), 64'd0);
    check("rst_scki", 64'(scki), 64'd0);
    check("rst_sdi", 64'(sdi), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_count", 64'(cnv_count), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    aresetn = 1'b1;
    tick();

    // Single start, channel 0, span 7
    enable = 1'b1; chan_mask = 8'h01; softspan = 3'b111;
    tick();
    check("lat_pre", 64'(cnv), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_cnv", 64'(cnv), 64'd1);
    check_pkt("t1", 8'h01, 3'b111, r);
    check("t1_count", 64'(cnv_count), 64'(m_count));
    check("t1_active", 64'(active), 64'd0);

    // Round robin over A4, then random masks
    chan_mask = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      softspan = 3'($urandom);
      pulse_start();
      check_pkt("rr", 8'hA4, softspan, r);
      repeat ($urandom_range(1, 20)) tick();
    end
    for (int i = 0; i < 4; i++) begin
      m = 8'($urandom_range(1, 255)); s = 3'($urandom);
      chan_mask = m; softspan = s;
      pulse_start();
      check_pkt("rnd", m, s, r);
      repeat ($urandom_range(1, 10)) tick();
    end

    // Start during an active packet is dropped and flagged
    pulse_start();
    repeat (20) tick();
    pulse_start();
    check("ovr_set", 64'(overrun), 64'd1);
    check_pkt("ovr", chan_mask, softspan, r);
    repeat (30) tick();
    check("ovr_drop", 64'(pk_q.size()), 64'd0);
    check("ovr_count", 64'(cnv_count), 64'(m_count));
    enable = 1'b0;
    tick(); tick();
    check("ovr_clr", 64'(overrun), 64'd0);

    // Free-running at period 200, then at 60 (every second trigger dropped)
    chan_mask = 8'($urandom_range(1, 255)); softspan = 3'($urandom);
    free_run = 1'b1; period = 32'd200; enable = 1'b1;
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      check_pkt("fr200", chan_mask, softspan, r);
      if (i > 0) check("fr200_spacing", 64'(r - prev), 64'd200);
      prev = r;
    end
    check("fr200_ovr", 64'(overrun), 64'd0);
    enable = 1'b0;
    tick(); tick();
    period = 32'd60; enable = 1'b1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      check_pkt("fr60", chan_mask, softspan, r);
      if (i > 0) check("fr60_spacing", 64'(r - prev), 64'd120);
      prev = r;
    end
    check("fr60_ovr", 64'(overrun), 64'd1);
    enable = 1'b0;
    tick(); tick();

    // Enable dropped mid-SHIFT: packet completes, nothing follows
    period = 32'd200; enable = 1'b1;
    wait_rises("dis", 5);
    enable = 1'b0;
    check_pkt("dis", chan_mask, softspan, r);
    base = n_cnv_rises;
    repeat (300) tick();
    check("dis_nocnv", 64'(n_cnv_rises), 64'(base));
    check("dis_count", 64'(cnv_count), 64'(m_count));
    check("dis_noq", 64'(pk_q.size()), 64'd0);
    free_run = 1'b0;

    // Async reset mid-SHIFT on channel 3, then restart from channel 0
    chan_mask = 8'h09; enable = 1'b1;
    for (int k = 0; k < 2 && first_set(8'h09, m_ptr) != 3; k++) begin
      pulse_start();
      check_pkt("pre", 8'h09, softspan, r);
    end
    pulse_start();
    wait_rises("ars", 3);
    check("ars_pre_scki", 64'(scki), 64'd1);
    aresetn = 1'b0;
    #1;
    check("ars_cnv", 64'(cnv), 64'd0);
    check("ars_scki", 64'(scki), 64'd0);
    check("ars_sdi", 64'(sdi), 64'd0);
    check("ars_active", 64'(active), 64'd0);
    m_ptr = 0; m_count = 0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
    pulse_start();
    check_pkt("post_rst", 8'h09, softspan, r);
    check("post_rst_count", 64'(cnv_count), 64'd1);

    // Empty mask: no conversions, no overrun
    chan_mask = 8'h00; base = n_cnv_rises;
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      repeat (10) tick();
    end
    free_run = 1'b1; period = 32'd60;
    repeat (300) tick();
    check("m0_nocnv", 64'(n_cnv_rises), 64'(base));
    check("m0_count", 64'(cnv_count), 64'(m_count));
    check("m0_ovr", 64'(overrun), 64'd0);
    check("m0_active", 64'(active), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
